// File: rtl/multi_project_select.sv
// Wishbone-controlled project selector: one-hot/zero active_o with an all-off guard drain on every change.
// Ack one cycle after request, every other cycle under back-to-back; optional LA override via PROJ_SEL_LA_OVERRIDE_EN.
module multi_project_select #(
   parameter int          NUM_PROJECTS = 16,
   parameter int          SEL_W        = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          GUARD_CYCLES = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_dat_i,
   input  logic [31:0]             wbs_adr_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   input  logic [31:0]             la_data_in,
   input  logic [31:0]             la_oen,
   output logic [NUM_PROJECTS-1:0] active_o,
   output logic                    busy_o
);
   localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, DRAIN, ENABLE} state_t;
   typedef struct packed {
      logic             en;
      logic [SEL_W-1:0] idx;
   } sel_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   sel_t                    committed_q, committed_d;
   sel_t                    applied_q, applied_d;
   sel_t                    target_q, target_d;
   logic                    err_q, err_d;
   logic                    ack_q, ack_d;
   logic                    busy_q, busy_d;
   logic [31:0]             dat_q, dat_d;
   logic [NUM_PROJECTS-1:0] active_q, active_d;

   logic [5:0] offset;
   logic       req, sel_wr, sts_wr, bad_idx, ovr;
   sel_t       wr_sel, eff_sel, nxt_sel;
   logic       unused_bits;

   function automatic logic [NUM_PROJECTS-1:0] onehot(input sel_t s);
      logic [NUM_PROJECTS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_PROJECTS; i++)
         v[i] = s.en && (s.idx == SEL_W'(i));
      return v;
   endfunction

`ifdef PROJ_SEL_LA_OVERRIDE_EN
   assign ovr     = !la_oen[31] && la_data_in[31];
   assign eff_sel = ovr ? {la_data_in[30], la_data_in[SEL_W-1:0]} : committed_q;
`else
   assign ovr     = 1'b0;
   assign eff_sel = committed_q;
`endif

   assign offset  = wbs_adr_i[7:2];
   assign req     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !ack_q;
   assign sel_wr  = req && wbs_we_i && (wbs_sel_i == 4'hF) && (offset == 6'd0);
   assign sts_wr  = req && wbs_we_i && (wbs_sel_i == 4'hF) && (offset == 6'd1);
   assign bad_idx = wbs_dat_i[31] && (32'(wbs_dat_i[SEL_W-1:0]) >= 32'(NUM_PROJECTS));
   assign wr_sel  = {wbs_dat_i[31] && !bad_idx, wbs_dat_i[SEL_W-1:0]};
   // While the override owns the selection, bus writes never reach the FSM.
   assign nxt_sel = (sel_wr && !ovr) ? wr_sel : eff_sel;

   assign unused_bits = ^{la_data_in, la_oen, wbs_adr_i[1:0], wbs_dat_i};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      committed_d = committed_q;
      applied_d   = applied_q;
      target_d    = target_q;
      err_d       = err_q;
      busy_d      = busy_q;
      active_d    = active_q;
      ack_d       = req;
      dat_d       = '0;

      if (req && !wbs_we_i) begin
         case (offset)
            6'd0:    dat_d = {committed_q.en, {(31-SEL_W){1'b0}}, committed_q.idx};
            6'd1:    dat_d = {29'd0, ovr, err_q, busy_q};
            6'd2:    dat_d = 32'(NUM_PROJECTS);
            default: dat_d = '0;
         endcase
      end

      // Clear first so a simultaneous set wins.
      if (sts_wr && wbs_dat_i[1]) err_d = 1'b0;
      if (sel_wr && !ovr && ((state_q == DRAIN) || bad_idx)) err_d = 1'b1;

      case (state_q)
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d   = ENABLE;
               busy_d    = 1'b0;
               active_d  = onehot(target_q);
               applied_d = target_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            if (sel_wr && !ovr) committed_d = wr_sel;
            if (nxt_sel != applied_q) begin
               state_d  = DRAIN;
               busy_d   = 1'b1;
               active_d = '0;
               cnt_d    = CNT_W'(GUARD_CYCLES - 1);
               target_d = nxt_sel;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         committed_q <= '0;
         applied_q   <= '0;
         target_q    <= '0;
         err_q       <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         dat_q       <= '0;
         active_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         committed_q <= committed_d;
         applied_q   <= applied_d;
         target_q    <= target_d;
         err_q       <= err_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         dat_q       <= dat_d;
         active_q    <= active_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign active_o  = active_q;
   assign busy_o    = busy_q;
endmodule

// File: tb/tb_multi_project_select.sv
// Bench for multi_project_select: register table, timed corner sequences and random traffic
// checked every cycle against a timeline model of the selection (guard window per change).
module tb_multi_project_select;
   localparam int          G    = 4;
   localparam int          NP   = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        wb_clk_i, wb_rst_i;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] la_data_in, la_oen;
   logic [NP-1:0] active_o;
   logic        busy_o;

   multi_project_select #(
      .NUM_PROJECTS(NP), .SEL_W(8), .BASE_ADDR(BASE), .GUARD_CYCLES(G)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .la_data_in(la_data_in), .la_oen(la_oen),
      .active_o(active_o), .busy_o(busy_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;
   bit chk_en   = 1'b1;

   // Model: committed selection, sticky err, and the timeline of the latest change.
   logic        m_en;
   logic [7:0]  m_idx;
   logic        m_err;
   int          sw_start, sw_end;
   logic [15:0] old_act, new_act;

   typedef struct {
      logic        we;
      logic [5:0]  off;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] rd;
      logic [15:0] act;
   } vec_t;
   localparam int NVEC = 19;
   vec_t vecs[NVEC];

   logic [31:0] rd, d, expv;
   logic [3:0]  be;
   logic [5:0]  off;
   int          r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_n, act, exp);
      end
   endtask

   function automatic logic exp_busy(input int c);
      return (c >= sw_start) && (c < sw_end);
   endfunction

   function automatic logic [15:0] exp_active(input int c);
      if (c < sw_start) return old_act;
      if (c < sw_end)   return 16'h0;
      return new_act;
   endfunction

   task automatic model_reset();
      m_en = 1'b0; m_idx = 8'd0; m_err = 1'b0;
      sw_start = 0; sw_end = 0; old_act = 16'h0; new_act = 16'h0;
   endtask

   task automatic model_write(input logic [5:0] o, input logic [31:0] wd, input logic [3:0] b, input int t);
      logic       nen, bad;
      logic [7:0] nidx;
      if (b != 4'hF) return;
      if (o == 6'd1) begin
         if (wd[1]) m_err = 1'b0;
         return;
      end
      if (o != 6'd0) return;
      if (exp_busy(t)) begin
         m_err = 1'b1;
         return;
      end
      nidx = wd[7:0];
      bad  = wd[31] && (nidx >= 8'(NP));
      nen  = wd[31] && !bad;
      if (bad) m_err = 1'b1;
      if (nen != m_en || nidx != m_idx) begin
         old_act  = exp_active(t);
         new_act  = nen ? (16'h1 << nidx) : 16'h0;
         sw_start = t + 1;
         sw_end   = t + 1 + G;
      end
      m_en = nen; m_idx = nidx;
   endtask

   function automatic logic [31:0] sel_val();
      return {m_en, 23'd0, m_idx};
   endfunction

   function automatic logic [31:0] status_val();
      return {29'd0, 1'b0, m_err, exp_busy(cyc_n)};
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
      cyc_n++;
      if (chk_en) begin
         chk("active", 32'(active_o), 32'(exp_active(cyc_n)));
         chk("busy", 32'(busy_o), 32'(exp_busy(cyc_n)));
         chk("at_most_one_active", 32'($countones(active_o) <= 1), 32'd1);
      end
   endtask

   task automatic bus_idle();
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_dat_i = '0; wbs_adr_i = '0;
   endtask

   task automatic xfer(input logic we, input logic [5:0] o, input logic [31:0] wd,
                       input logic [3:0] b, output logic [31:0] rdat);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = BASE | {24'd0, o, 2'b00}; wbs_dat_i = wd; wbs_sel_i = b;
      if (we) model_write(o, wd, b, cyc_n);
      tick();
      chk("ack", 32'(wbs_ack_o), 32'd1);
      rdat = wbs_dat_o;
      bus_idle();
      tick();
      chk("ack_low", 32'(wbs_ack_o), 32'd0);
      chk("dat_idle", wbs_dat_o, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0, 6'd2, 32'h0,         4'hF, 32'd16,        16'h0000};
      vecs[1]  = '{1'b0, 6'd0, 32'h0,         4'hF, 32'h0,         16'h0000};
      vecs[2]  = '{1'b1, 6'd0, 32'h8000_0003, 4'hF, 32'h0,         16'h0008};
      vecs[3]  = '{1'b0, 6'd0, 32'h0,         4'hF, 32'h8000_0003, 16'h0008};
      vecs[4]  = '{1'b1, 6'd0, 32'h8000_0005, 4'hF, 32'h0,         16'h0020};
      vecs[5]  = '{1'b1, 6'd0, 32'h8000_0001, 4'h3, 32'h0,         16'h0020};
      vecs[6]  = '{1'b0, 6'd0, 32'h0,         4'hF, 32'h8000_0005, 16'h0020};
      vecs[7]  = '{1'b1, 6'd0, 32'h8000_0014, 4'hF, 32'h0,         16'h0000};
      vecs[8]  = '{1'b0, 6'd1, 32'h0,         4'hF, 32'h2,         16'h0000};
      vecs[9]  = '{1'b0, 6'd0, 32'h0,         4'hF, 32'h0000_0014, 16'h0000};
      vecs[10] = '{1'b1, 6'd1, 32'h2,         4'hF, 32'h0,         16'h0000};
      vecs[11] = '{1'b0, 6'd1, 32'h0,         4'hF, 32'h0,         16'h0000};
      vecs[12] = '{1'b1, 6'd3, 32'hFFFF_FFFF, 4'hF, 32'h0,         16'h0000};
      vecs[13] = '{1'b0, 6'd3, 32'h0,         4'hF, 32'h0,         16'h0000};
      vecs[14] = '{1'b1, 6'd0, 32'h8000_000F, 4'hF, 32'h0,         16'h8000};
      vecs[15] = '{1'b0, 6'd0, 32'h0,         4'hF, 32'h8000_000F, 16'h8000};
      vecs[16] = '{1'b1, 6'd0, 32'h0000_000F, 4'hF, 32'h0,         16'h0000};
      vecs[17] = '{1'b1, 6'd0, 32'h8000_0000, 4'hF, 32'h0,         16'h0001};
      vecs[18] = '{1'b1, 6'd0, 32'h8000_0000, 4'hF, 32'h0,         16'h0001};

      wb_rst_i = 1'b1;
      bus_idle();
      la_oen = '1; la_data_in = '0;
      model_reset();
      repeat (3) tick();
      chk("rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rst_dat", wbs_dat_o, 32'd0);
      chk("rst_active", 32'(active_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      #2 wb_rst_i = 1'b0;
      repeat (2) tick();

      // Register table.
      for (int i = 0; i < NVEC; i++) begin
         xfer(vecs[i].we, vecs[i].off, vecs[i].wd, vecs[i].be, rd);
         if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
         repeat (G + 1) tick();
         chk($sformatf("vec%0d_act", i), 32'(active_o), 32'(vecs[i].act));
      end

      // Exact guard timing of a switch from project 0 to project 7.
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = BASE; wbs_dat_i = 32'h8000_0007; wbs_sel_i = 4'hF;
      model_write(6'd0, 32'h8000_0007, 4'hF, cyc_n);
      tick();
      chk("tm_ack", 32'(wbs_ack_o), 32'd1);
      bus_idle();
      for (int k = 1; k <= G + 1; k++) begin
         if (k > 1) tick();
         chk($sformatf("tm_busy_T+%0d", k), 32'(busy_o), (k <= G) ? 32'd1 : 32'd0);
         chk($sformatf("tm_act_T+%0d", k), 32'(active_o), (k <= G) ? 32'h0 : 32'h80);
      end

      // SEL write during the drain is acked, ignored and flags err.
      xfer(1'b1, 6'd0, 32'h8000_0002, 4'hF, rd);
      xfer(1'b1, 6'd0, 32'h8000_0009, 4'hF, rd);
      repeat (G + 2) tick();
      chk("busy_wr_act", 32'(active_o), 32'h0004);
      xfer(1'b0, 6'd1, 32'h0, 4'hF, rd);
      chk("busy_wr_status", rd, 32'h2);
      xfer(1'b1, 6'd1, 32'h2, 4'hF, rd);

      // Back-to-back requests: ack every other cycle.
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = BASE | 32'h8; wbs_sel_i = 4'hF;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("b2b_ack", 32'(wbs_ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_dat", wbs_dat_o, (k % 2 == 0) ? 32'd16 : 32'd0);
      end
      // Addresses outside the window are never acked.
      wbs_adr_i = BASE | 32'h108;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("nomatch_ack", 32'(wbs_ack_o), 32'd0);
      end
      wbs_adr_i = 32'h4000_0000; wbs_we_i = 1'b1; wbs_dat_i = 32'h8000_0001;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("nomatch2_ack", 32'(wbs_ack_o), 32'd0);
      end
      bus_idle();
      tick();

      // Reset in the middle of a drain.
      xfer(1'b1, 6'd0, 32'h8000_000A, 4'hF, rd);
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      wb_rst_i = 1'b1;
      model_reset();
      #2;
      chk("mid_rst_active", 32'(active_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      repeat (2) tick();
      wb_rst_i = 1'b0;
      repeat (G + 3) tick();
      xfer(1'b0, 6'd0, 32'h0, 4'hF, rd);
      chk("post_rst_sel", rd, 32'h0);
      chk("post_rst_active", 32'(active_o), 32'd0);

      // Random traffic against the model.
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            d  = {1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom), 8'($urandom_range(0, 19))};
            be = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            xfer(1'b1, 6'd0, d, be, rd);
         end else if (r < 7) begin
            off  = (r == 5) ? 6'd0 : 6'd1;
            expv = (r == 5) ? sel_val() : status_val();
            xfer(1'b0, off, 32'h0, 4'hF, rd);
            chk("rand_rd", rd, expv);
         end else if (r == 7) begin
            d = 32'($urandom);
            xfer(1'b1, 6'd1, d, 4'hF, rd);
         end else begin
            repeat ($urandom_range(1, 6)) tick();
         end
      end
      repeat (G + 2) tick();

`ifdef PROJ_SEL_LA_OVERRIDE_EN
      chk_en = 1'b0;
      la_oen = 32'h7FFF_FFFF; la_data_in = 32'hC000_0002;
      repeat (2 * G + 4) tick();
      chk("ovr_active", 32'(active_o), 32'h0004);
      xfer(1'b0, 6'd1, 32'h0, 4'hF, rd);
      chk("ovr_status_bit2", rd & 32'h4, 32'h4);
      la_oen = '1; la_data_in = '0;
      repeat (2 * G + 4) tick();
      chk("ovr_release", 32'(active_o), m_en ? 32'(16'h1 << m_idx) : 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_project_select.md
Name: multi_project_select

Overview:
Wishbone-controlled project selector for the shared user area: one `active` line per project, driven onto each project's tristate wrapper.
- Guarantees at most one project is active at any time.
- Every switch-over passes through a guard interval with all projects inactive, so no two tristated buses are driven at once.
- Generalises the single `active` input of one project wrapper to N selectable projects, with status and an optional logic-analyser override.

Parameters:
NUM_PROJECTS, 16, number of project slots (2..256)
SEL_W, 8, width of the project index field (2^SEL_W >= NUM_PROJECTS)
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode on adr[31:8]
GUARD_CYCLES, 4, all-inactive cycles between deselect and select (>=1)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset, asynchronous, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  address
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
la_data_in  input  32  logic analyser data (override feature only)
la_oen  input  32  logic analyser output-enable, active-low (override feature only)
active_o  output  NUM_PROJECTS  one-hot/zero project enables
busy_o  output  1  high while a switch-over is in progress

Behaviour:
- Reset (async assert, sync release): active_o=0, busy_o=0, wbs_ack_o=0, wbs_dat_o=0, FSM=IDLE, SEL register=0 (enable bit clear), err=0.
- Access: request = stb & cyc & (adr[31:8]==BASE_ADDR[31:8]) & !wbs_ack_o.
  - Unmatched address: never acked.
  - Matched: wbs_ack_o is registered, high exactly 1 cycle after the request. It is low the following cycle, so back-to-back requests are acked every other cycle.
  - Read data is valid with ack; wbs_dat_o=0 when not acking.
- Register map, offset adr[7:2]:
  - 0 SEL: bit31 enable, bits[SEL_W-1:0] index. Read returns the committed value.
  - 1 STATUS: bit0 busy, bit1 err (sticky), bit2 override active. Write 1 to bit1 clears err.
  - 2 ID: read-only constant NUM_PROJECTS.
  - Other offsets: read 0, writes ignored, still acked.
- Writes take effect only when wbs_sel_i==4'hF. Any other byte-select pattern is acked with no effect.
- FSM states IDLE, DRAIN, ENABLE:
  - IDLE: a valid SEL write accepted at cycle T, whose value differs from the committed value, moves the FSM to DRAIN. From T+1: active_o=0, busy_o=1, guard counter loaded with GUARD_CYCLES-1.
  - DRAIN: counter decrements each cycle; at 0, go to ENABLE.
  - ENABLE: one cycle, then IDLE. At T+1+GUARD_CYCLES, active_o = onehot(index) if enable=1, else 0, and busy_o=0.
  - Example, GUARD_CYCLES=4: active_o zero T+1..T+4; new value at T+5.
- SEL write equal to the committed value: acked, no transition, no drain.
- Index >= NUM_PROJECTS with enable=1:
  - SEL is committed with enable forced to 0.
  - err is set.
  - Normal drain runs, ending with active_o=0.
- SEL write while busy_o=1: acked, ignored, err set.
- STATUS write with bit1=1 in the same cycle as an err-setting event: set wins.
- active_o is registered directly from flops; never more than one bit high in any cycle, including reset exit.
- Reset asserted mid-DRAIN: immediate return to reset values; no selection resumes after release.

Optional Feature:
Macro: PROJ_SEL_LA_OVERRIDE_EN
- With the macro defined: when la_oen[31]==0 and la_data_in[31]==1, the override is active.
  - The effective selection is enable=la_data_in[30], index=la_data_in[SEL_W-1:0].
  - Changes to the effective selection run the same DRAIN/ENABLE sequence.
  - Wishbone SEL writes are acked but ignored; err is not set.
  - On override release, the FSM transitions back to the committed SEL value through a drain.
  - STATUS bit2 reflects the override state.
- Without the macro: la_data_in and la_oen are unused, and STATUS bit2 reads 0.

Test Plan:
1. Reset, then read ID at BASE+0x08 -> ack 1 cycle after request, data 16; active_o=0 throughout.
2. Write SEL=0x8000_0003 at cycle T (GUARD_CYCLES=4) -> busy_o high T+1..T+4, active_o=0 T+1..T+4, active_o=16'h0008 at T+5, busy_o=0.
3. With project 3 active, write SEL=0x8000_0005 -> active_o drops to 0 for 4 cycles, then 16'h0020; never two bits high in any cycle.
4. Write SEL=0x8000_0014 (index 20) -> STATUS reads 0x2 after drain, active_o=0; write STATUS=0x2 -> STATUS reads 0.
5. Write SEL during busy -> acked, active_o follows the first write only, err=1. Separately: assert wb_rst_i mid-DRAIN -> active_o=0, busy_o=0 and SEL reads 0 after release.
6. (PROJ_SEL_LA_OVERRIDE_EN) la_oen[31]=0, la_data_in=0xC000_0002 -> active_o=16'h0004 after guard, STATUS bit2=1; release the override -> drain back to the committed SEL value.
